// File: rtl/decode_queue_if.sv
// Fetch/dispatch-facing bundle for decode_queue; master = fetch+dispatch side, slave = queue.
// out_illegal exists only when DECODE_ILLEGAL_EN is defined.
interface decode_queue_if #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                 flush;
  logic                 in_valid;
  logic [CNT_W-1:0]     in_cnt;
  logic [WIDTH*32-1:0]  in_inst;
  logic [31:0]          in_pc;
  logic                 in_ready;
  logic [OCC_W-1:0]     occupancy;
  logic [WIDTH-1:0]     out_valid;
  logic [CNT_W-1:0]     out_pop;
  logic [WIDTH*32-1:0]  out_pc;
  logic [WIDTH*32-1:0]  out_imm;
  logic [WIDTH*7-1:0]   out_opcode;
  logic [WIDTH*7-1:0]   out_funct7;
  logic [WIDTH*3-1:0]   out_funct3;
  logic [WIDTH*5-1:0]   out_rs1;
  logic [WIDTH*5-1:0]   out_rs2;
  logic [WIDTH*5-1:0]   out_rd;
`ifdef DECODE_ILLEGAL_EN
  logic [WIDTH-1:0]     out_illegal;
`endif

  modport master (
    output flush, in_valid, in_cnt, in_inst, in_pc, out_pop,
    input  in_ready, occupancy, out_valid, out_pc, out_imm, out_opcode,
           out_funct7, out_funct3, out_rs1, out_rs2, out_rd
`ifdef DECODE_ILLEGAL_EN
    , input out_illegal
`endif
  );

  modport slave (
    input  flush, in_valid, in_cnt, in_inst, in_pc, out_pop,
    output in_ready, occupancy, out_valid, out_pc, out_imm, out_opcode,
           out_funct7, out_funct3, out_rs1, out_rs2, out_rd
`ifdef DECODE_ILLEGAL_EN
    , output out_illegal
`endif
  );
endinterface

// File: rtl/decode_queue.sv
// Multi-wide RV32I decode into a circular buffer of decoded entries, read from the head by dispatch.
// Optional feature: define DECODE_ILLEGAL_EN to classify and flag illegal instructions per entry.
module decode_queue #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  decode_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
`ifdef DECODE_ILLEGAL_EN
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
`ifdef DECODE_ILLEGAL_EN
    logic        illegal;
`endif
  } entry_t;

  function automatic entry_t decode(input logic [31:0] inst, input logic [31:0] pc);
    entry_t e;
    e        = '0;
    e.pc     = pc;
    e.opcode = inst[6:0];
    e.rd     = inst[11:7];
    e.funct3 = inst[14:12];
    e.rs1    = inst[19:15];
    e.rs2    = inst[24:20];
    e.funct7 = inst[31:25];
    case (inst[6:0])
      OP_JALR, OP_IMM, OP_LOAD: e.imm = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:  e.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH: e.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC: e.imm = {inst[31:12], 12'h000};
      OP_JAL:    e.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:   e.imm = '0;
    endcase
`ifdef DECODE_ILLEGAL_EN
    e.illegal = (inst[1:0] != 2'b11) ||
                !(inst[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                                    OP_STORE, OP_IMM, OP_OP, OP_MISC, OP_SYSTEM});
    if (e.illegal) e.imm = '0;
`endif
    return e;
  endfunction

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OCC_W-1:0] push_n, pop_n, pop_req;
  logic             in_ready;

  // Readiness looks only at registered occupancy; same-cycle pops are not credited.
  assign in_ready = (occ_q <= OCC_W'(DEPTH - WIDTH));

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned (no latch).
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    push_n  = '0;
    pop_req = OCC_W'(bus.out_pop);
    pop_n   = pop_req;

    if (bus.in_valid && in_ready && !bus.flush) begin
      push_n = (bus.in_cnt > CNT_W'(WIDTH)) ? OCC_W'(WIDTH) : OCC_W'(bus.in_cnt);
    end
    // Dispatch may over-ask; clamp to what is held and to the window width.
    if (pop_n > occ_q)          pop_n = occ_q;
    if (pop_n > OCC_W'(WIDTH))  pop_n = OCC_W'(WIDTH);

    for (int i = 0; i < WIDTH; i++) begin
      if (OCC_W'(i) < push_n) begin
        mem_d[tail_q + PTR_W'(i)] = decode(bus.in_inst[32*i +: 32], bus.in_pc + 32'(4 * i));
      end
    end

    if (bus.flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      head_d = head_q + PTR_W'(pop_n);
      tail_d = tail_q + PTR_W'(push_n);
      occ_d  = occ_q + push_n - pop_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      // NOTE: storage is reset so head-window fields of invalid lanes never show X downstream.
      mem_q  <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      mem_q  <= mem_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.occupancy = occ_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    entry_t e;
    assign e                          = mem_q[head_q + PTR_W'(g)];
    assign bus.out_valid[g]           = (occ_q > OCC_W'(g));
    assign bus.out_pc[32*g +: 32]     = e.pc;
    assign bus.out_imm[32*g +: 32]    = e.imm;
    assign bus.out_opcode[7*g +: 7]   = e.opcode;
    assign bus.out_funct7[7*g +: 7]   = e.funct7;
    assign bus.out_funct3[3*g +: 3]   = e.funct3;
    assign bus.out_rs1[5*g +: 5]      = e.rs1;
    assign bus.out_rs2[5*g +: 5]      = e.rs2;
    assign bus.out_rd[5*g +: 5]       = e.rd;
`ifdef DECODE_ILLEGAL_EN
    assign bus.out_illegal[g]         = e.illegal;
`endif
  end
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (WIDTH=2, DEPTH=8): decode fields, immediates, fill/wrap,
// push/pop overlap, pop clamping, flush and asynchronous reset.
module tb_decode_queue;
  localparam int WIDTH = 2;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  decode_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addi(input int n);
    return {12'(n), 13'h0, 7'h13};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_cnt   = '0;
    bus.in_inst  = '0;
    bus.in_pc    = '0;
    bus.out_pop  = '0;
  endtask

  task automatic drive(input int cnt, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_cnt   = 2'(cnt);
    bus.in_inst  = {i1, i0};
    bus.in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_occ",   32'(bus.occupancy), 32'd0);
    chk("rst_ready", 32'(bus.in_ready),  32'd1);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_imm",   bus.out_imm[31:0],  32'd0);
    chk("rst_pc1",   bus.out_pc[63:32],  32'd0);
    rst = 1'b0;

    // addi x1,x0,5 / addi x2,x0,-1
    drive(2, 32'h00500093, 32'hFFF00113, 32'h1000);
    tick();
    idle();
    chk("t1_valid", 32'(bus.out_valid),   32'd3);
    chk("t1_occ",   32'(bus.occupancy),   32'd2);
    chk("t1_imm0",  bus.out_imm[31:0],    32'd5);
    chk("t1_imm1",  bus.out_imm[63:32],   32'hFFFFFFFF);
    chk("t1_rd0",   32'(bus.out_rd[4:0]), 32'd1);
    chk("t1_rd1",   32'(bus.out_rd[9:5]), 32'd2);
    chk("t1_pc0",   bus.out_pc[31:0],     32'h1000);
    chk("t1_pc1",   bus.out_pc[63:32],    32'h1004);
    chk("t1_opc0",  32'(bus.out_opcode[6:0]), 32'h13);
    bus.out_pop = 2'd2;
    tick();
    bus.out_pop = '0;
    chk("t1_drain_occ",   32'(bus.occupancy), 32'd0);
    chk("t1_drain_valid", 32'(bus.out_valid), 32'd0);

    // sw x1,-4(x2) / beq x0,x0,-4
    drive(2, 32'hFE112E23, 32'hFE000EE3, 32'h2000);
    tick();
    idle();
    chk("sw_imm",    bus.out_imm[31:0],       32'hFFFFFFFC);
    chk("beq_imm",   bus.out_imm[63:32],      32'hFFFFFFFC);
    chk("sw_rs1",    32'(bus.out_rs1[4:0]),   32'd2);
    chk("sw_rs2",    32'(bus.out_rs2[4:0]),   32'd1);
    chk("sw_funct3", 32'(bus.out_funct3[2:0]), 32'd2);
    chk("beq_f7",    32'(bus.out_funct7[13:7]), 32'h7F);
    bus.out_pop = 2'd2;
    tick();
    // jal x0,8 / lui x0,0x12345
    drive(2, 32'h0080006F, 32'h12345037, 32'h2100);
    bus.out_pop = '0;
    tick();
    idle();
    chk("jal_imm", bus.out_imm[31:0],  32'd8);
    chk("lui_imm", bus.out_imm[63:32], 32'h12345000);
    chk("lui_pc",  bus.out_pc[63:32],  32'h2104);
    bus.out_pop = 2'd2;
    tick();
    bus.out_pop = '0;

    // Fill from head=tail=6 so the tail wraps through index 0.
    for (int g = 0; g < 4; g++) begin
      drive(2, addi(2 * g), addi(2 * g + 1), 32'h3000 + 32'(8 * g));
      tick();
      chk("fill_occ", 32'(bus.occupancy), 32'(2 * g + 2));
    end
    idle();
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    chk("full_pc0",   bus.out_pc[31:0],  32'h3000);
    chk("full_pc1",   bus.out_pc[63:32], 32'h3004);

    drive(2, addi(99), addi(99), 32'h9000);
    tick();
    idle();
    chk("blocked_occ", 32'(bus.occupancy), 32'd8);
    chk("blocked_pc0", bus.out_pc[31:0],   32'h3000);

    bus.out_pop = 2'd1;
    tick();
    bus.out_pop = '0;
    chk("pop1_occ",   32'(bus.occupancy), 32'd7);
    chk("pop1_ready", 32'(bus.in_ready),  32'd0);
    chk("pop1_pc0",   bus.out_pc[31:0],   32'h3004);
    chk("pop1_imm1",  bus.out_imm[63:32], 32'd2);

    bus.out_pop = 2'd2;
    tick();
    bus.out_pop = '0;
    chk("pop2_occ",   32'(bus.occupancy), 32'd5);
    chk("pop2_ready", 32'(bus.in_ready),  32'd1);
    chk("pop2_pc0",   bus.out_pc[31:0],   32'h300C);
    chk("pop2_imm1",  bus.out_imm[63:32], 32'd4);

    drive(2, addi(8), addi(9), 32'h4000);
    bus.out_pop = 2'd1;
    tick();
    idle();
    chk("pp_occ", 32'(bus.occupancy), 32'd6);
    chk("pp_pc0", bus.out_pc[31:0],   32'h3010);
    chk("pp_pc1", bus.out_pc[63:32],  32'h3014);

    drive(2, addi(1), addi(1), 32'h8000);
    bus.out_pop = 2'd1;
    bus.flush   = 1'b1;
    tick();
    idle();
    chk("flush_occ",   32'(bus.occupancy), 32'd0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_ready", 32'(bus.in_ready),  32'd1);

    drive(1, addi(7), 32'h0, 32'h5000);
    tick();
    idle();
    chk("one_occ",   32'(bus.occupancy), 32'd1);
    chk("one_valid", 32'(bus.out_valid), 32'd1);
    chk("one_imm0",  bus.out_imm[31:0],  32'd7);
    bus.out_pop = 2'd2;
    tick();
    bus.out_pop = '0;
    chk("clamp_occ", 32'(bus.occupancy), 32'd0);
    drive(2, addi(10), addi(11), 32'h6000);
    tick();
    idle();
    chk("clamp_occ2", 32'(bus.occupancy), 32'd2);
    chk("clamp_pc0",  bus.out_pc[31:0],   32'h6000);
    chk("clamp_imm0", bus.out_imm[31:0],  32'd10);
    bus.out_pop = 2'd2;
    tick();
    bus.out_pop = '0;

`ifdef DECODE_ILLEGAL_EN
    drive(2, 32'h0000007F, 32'h00000000, 32'h7100);
    tick();
    idle();
    chk("ill_flags", 32'(bus.out_illegal), 32'd3);
    chk("ill_imm0",  bus.out_imm[31:0],    32'd0);
    chk("ill_imm1",  bus.out_imm[63:32],   32'd0);
    bus.out_pop = 2'd2;
    tick();
    drive(2, 32'h002081B3, 32'h00500093, 32'h7200);
    bus.out_pop = '0;
    tick();
    idle();
    chk("legal_flags", 32'(bus.out_illegal), 32'd0);
    chk("legal_imm1",  bus.out_imm[63:32],   32'd5);
    bus.out_pop = 2'd2;
    tick();
    bus.out_pop = '0;
`endif

    // Asynchronous reset mid-push, then the first edge after release pushes.
    drive(2, addi(3), addi(4), 32'h7000);
    tick();
    chk("pre_rst_occ", 32'(bus.occupancy), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_occ",   32'(bus.occupancy), 32'd0);
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_ready", 32'(bus.in_ready),  32'd1);
    chk("arst_pc0",   bus.out_pc[31:0],   32'd0);
    tick();
    chk("rst_hold_occ", 32'(bus.occupancy), 32'd0);
    rst = 1'b0;
    tick();
    idle();
    chk("post_rst_occ", 32'(bus.occupancy), 32'd2);
    chk("post_rst_pc0", bus.out_pc[31:0],   32'h7000);
    chk("post_rst_imm1", bus.out_imm[63:32], 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
